// File: rtl/score_table_ctrl.sv
// Read-modify-write controller for a single-port score RAM, with a flow-controlled table dump
// and running best-score tracking.
module score_table_ctrl #(
  parameter int ID_W    = 16,
  parameter int SCORE_W = 16,
  parameter int RAM_LAT = 2,
  parameter int MODE    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         game_state,
  input  logic [ID_W-1:0]    userid,
  input  logic [SCORE_W-1:0] score_data,
  input  logic [SCORE_W-1:0] ram_q,
  output logic               ram_wren,
  output logic [ID_W-1:0]    ram_addr,
  output logic [SCORE_W-1:0] ram_d,
  output logic               dump_valid,
  input  logic               dump_ready,
  output logic [ID_W-1:0]    dump_id,
  output logic [SCORE_W-1:0] dump_score,
  output logic               dump_last,
  output logic               busy,
  output logic [ID_W-1:0]    best_id,
  output logic [SCORE_W-1:0] best_score,
  output logic [2:0]         fsm_state
);

  localparam int CNT_W = $clog2(RAM_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(RAM_LAT);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    U_RD   = 3'd1,
    U_WAIT = 3'd2,
    U_WR   = 3'd3,
    D_RD   = 3'd4,
    D_WAIT = 3'd5,
    D_OUT  = 3'd6
  } state_t;

  state_t             state;
  logic [1:0]         gs_prev;
  logic [CNT_W-1:0]   cnt;
  logic [SCORE_W-1:0] op_score;
  logic [SCORE_W:0]   sum;
  logic [SCORE_W-1:0] new_val;
  logic               req_edge;

  assign fsm_state = state;
  assign req_edge  = (game_state != gs_prev);

  always_comb begin
    sum     = {1'b0, ram_q} + {1'b0, op_score};
    new_val = op_score;
    case (MODE)
      1:       new_val = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
      2:       new_val = (ram_q > op_score) ? ram_q : op_score;
      default: new_val = op_score;
    endcase
  end

  // Dump handshake: dump_id/dump_score/dump_last are held while dump_valid is high and
  // dump_ready is low; an entry transfers on the rising edge where both are high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      gs_prev    <= '0;
      cnt        <= '0;
      op_score   <= '0;
      ram_wren   <= 1'b0;
      ram_addr   <= '0;
      ram_d      <= '0;
      dump_valid <= 1'b0;
      dump_id    <= '0;
      dump_score <= '0;
      dump_last  <= 1'b0;
      busy       <= 1'b0;
      best_id    <= '0;
      best_score <= '0;
    end else begin
      gs_prev <= game_state;
      case (state)
        IDLE: begin
          if (req_edge && game_state == 2'b01) begin
            ram_addr <= userid;
            op_score <= score_data;
            busy     <= 1'b1;
            state    <= U_RD;
          end else if (req_edge && game_state == 2'b10) begin
            ram_addr <= '0;
            busy     <= 1'b1;
            state    <= D_RD;
          end
        end
        U_RD: begin
          cnt   <= CNT_W'(1);
          state <= U_WAIT;
        end
        U_WAIT: begin
          if (cnt == LAT_C) begin
            ram_d    <= new_val;
            ram_wren <= 1'b1;
            state    <= U_WR;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        U_WR: begin
          // Strict compare so a tie keeps the id that reached the score first.
          if (ram_d > best_score) begin
            best_score <= ram_d;
            best_id    <= ram_addr;
          end
          ram_wren <= 1'b0;
          ram_addr <= '0;
          ram_d    <= '0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        D_RD: begin
          cnt   <= CNT_W'(1);
          state <= D_WAIT;
        end
        D_WAIT: begin
          if (cnt == LAT_C) begin
            dump_score <= ram_q;
            dump_id    <= ram_addr;
            dump_last  <= &ram_addr;
            dump_valid <= 1'b1;
            state      <= D_OUT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        D_OUT: begin
          if (dump_ready) begin
            dump_valid <= 1'b0;
            if (dump_last) begin
              ram_addr <= '0;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              ram_addr <= ram_addr + ID_W'(1);
              state    <= D_RD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_table_ctrl.sv
// Bench for score_table_ctrl: one accumulate instance and one keep-max instance share
// stimulus, each with its own RAM model; a scoreboard checks writes and dump entries.
module tb_score_table_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  game_state = 2'b00;
  logic [2:0]  userid = '0;
  logic [15:0] score_data = '0;
  logic        dump_ready = 1'b0;

  logic        ram_wren [2];
  logic [2:0]  ram_addr [2];
  logic [15:0] ram_d [2];
  logic        dump_valid [2];
  logic [2:0]  dump_id [2];
  logic [15:0] dump_score [2];
  logic        dump_last [2];
  logic        busy [2];
  logic [2:0]  best_id [2];
  logic [15:0] best_score [2];
  logic [2:0]  fsm_state [2];

  logic        bd_en = 1'b0;
  logic [2:0]  bd_addr = '0;
  logic [15:0] bd_data [2];

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          ready_mode = 0;

  typedef struct packed {
    int unsigned c;
    logic [2:0]  a;
    logic [15:0] d0;
    logic [15:0] d1;
  } wr_t;

  typedef struct packed {
    int unsigned c;
    logic [2:0]  id;
    logic [15:0] s0;
    logic [15:0] s1;
    logic        last;
  } dp_t;

  wr_t wr_q [$];
  dp_t dp_q [$];

  // Reference table contents and best trackers for the two update rules
  int unsigned tbl0 [8];
  int unsigned tbl1 [8];
  int unsigned best0 = 0, bid0 = 0, best1 = 0, bid1 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [15:0] mem [8];
    logic [15:0] p0, p1;

    always @(posedge clk) begin
      p0 <= mem[ram_addr[g]];
      p1 <= p0;
      if (bd_en) mem[bd_addr] <= bd_data[g];
      else if (ram_wren[g]) mem[ram_addr[g]] <= ram_d[g];
    end

    score_table_ctrl #(.ID_W(3), .SCORE_W(16), .RAM_LAT(2), .MODE(g + 1)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .game_state (game_state),
      .userid     (userid),
      .score_data (score_data),
      .ram_q      (p1),
      .ram_wren   (ram_wren[g]),
      .ram_addr   (ram_addr[g]),
      .ram_d      (ram_d[g]),
      .dump_valid (dump_valid[g]),
      .dump_ready (dump_ready),
      .dump_id    (dump_id[g]),
      .dump_score (dump_score[g]),
      .dump_last  (dump_last[g]),
      .busy       (busy[g]),
      .best_id    (best_id[g]),
      .best_score (best_score[g]),
      .fsm_state  (fsm_state[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int unsigned model_merge(input int mode, input int unsigned old,
                                              input int unsigned op);
    if (mode == 1) return (old + op > 65535) ? 65535 : old + op;
    return (old > op) ? old : op;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (busy[0] || busy[1]) begin
      @(posedge clk); #1;
      n++;
      if (n > 100) begin
        chk("idle_timeout", 1, 0);
        break;
      end
    end
  endtask

  task automatic backdoor(input logic [2:0] a, input logic [15:0] v0, input logic [15:0] v1);
    bd_en = 1'b1; bd_addr = a; bd_data[0] = v0; bd_data[1] = v1;
    tbl0[a] = v0; tbl1[a] = v1;
    @(posedge clk); #1;
    bd_en = 1'b0;
  endtask

  task automatic check_best();
    chk("best_score0", best_score[0], best0);
    chk("best_id0", best_id[0], bid0);
    chk("best_score1", best_score[1], best1);
    chk("best_id1", best_id[1], bid1);
  endtask

  task automatic do_update(input logic [2:0] id, input logic [15:0] sc, input int hold,
                           input bit toggle);
    wr_t e;
    int unsigned nv0, nv1;
    wait_idle();
    nv0 = model_merge(1, tbl0[id], sc);
    nv1 = model_merge(2, tbl1[id], sc);
    e.c = cyc + 4; e.a = id; e.d0 = nv0[15:0]; e.d1 = nv1[15:0];
    wr_q.push_back(e);
    tbl0[id] = nv0; tbl1[id] = nv1;
    if (nv0 > best0) begin best0 = nv0; bid0 = id; end
    if (nv1 > best1) begin best1 = nv1; bid1 = id; end
    game_state = 2'b01; userid = id; score_data = sc;
    repeat (hold) begin @(posedge clk); #1; end
    game_state = 2'b00;
    if (toggle) begin
      @(posedge clk); #1; game_state = 2'b01;
      @(posedge clk); #1; game_state = 2'b00;
    end
    wait_idle();
    check_best();
  endtask

  task automatic do_dump(input bit fast);
    dp_t d;
    int unsigned c0;
    int n = 0;
    wait_idle();
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      d.id = 3'(i); d.s0 = tbl0[i][15:0]; d.s1 = tbl1[i][15:0]; d.last = (i == 7);
      d.c = fast ? c0 + 4 + 4 * i : 0;
      dp_q.push_back(d);
    end
    ready_mode = fast ? 2 : 1;
    game_state = 2'b10;
    @(posedge clk); #1;
    game_state = 2'b00;
    while (dp_q.size() != 0 || busy[0] || busy[1]) begin
      @(posedge clk); #1;
      n++;
      if (n > 500) begin
        chk("dump_timeout", 1, 0);
        break;
      end
    end
    ready_mode = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int g = 0; g < 2; g++) begin
      chk({tag, "_ram_wren"}, ram_wren[g], 0);
      chk({tag, "_ram_addr"}, ram_addr[g], 0);
      chk({tag, "_ram_d"}, ram_d[g], 0);
      chk({tag, "_dump_valid"}, dump_valid[g], 0);
      chk({tag, "_dump_id"}, dump_id[g], 0);
      chk({tag, "_dump_score"}, dump_score[g], 0);
      chk({tag, "_dump_last"}, dump_last[g], 0);
      chk({tag, "_busy"}, busy[g], 0);
      chk({tag, "_best_id"}, best_id[g], 0);
      chk({tag, "_best_score"}, best_score[g], 0);
    end
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_release0", fsm_state[0], 0);
    chk("idle_after_release1", fsm_state[1], 0);
    best0 = 0; bid0 = 0; best1 = 0; bid1 = 0;
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        1:       dump_ready = ($urandom_range(0, 2) == 0);
        2:       dump_ready = 1'b1;
        default: dump_ready = 1'b0;
      endcase
    end
  end

  // Write monitor
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst && (ram_wren[0] || ram_wren[1])) begin
        if (wr_q.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          e = wr_q.pop_front();
          chk("write_en_both", {31'd0, ram_wren[0] & ram_wren[1]}, 1);
          chk("write_cycle", cyc, e.c);
          chk("write_addr0", ram_addr[0], e.a);
          chk("write_addr1", ram_addr[1], e.a);
          chk("write_data0", ram_d[0], e.d0);
          chk("write_data1", ram_d[1], e.d1);
        end
      end
    end
  end

  // Dump monitor
  initial begin
    dp_t e;
    bit stalled = 0;
    logic [2:0] sid;
    logic [15:0] ss0, ss1;
    logic sl;
    forever begin
      @(negedge clk);
      if (!rst) stalled = 0;
      else if (dump_valid[0] || dump_valid[1]) begin
        if (stalled) begin
          chk("stall_id", dump_id[0], sid);
          chk("stall_score0", dump_score[0], ss0);
          chk("stall_score1", dump_score[1], ss1);
          chk("stall_last", dump_last[0], sl);
        end
        if (dump_ready) begin
          stalled = 0;
          if (dp_q.size() == 0) chk("unexpected_dump", 1, 0);
          else begin
            e = dp_q.pop_front();
            chk("dump_valid_both", {31'd0, dump_valid[0] & dump_valid[1]}, 1);
            chk("dump_id0", dump_id[0], e.id);
            chk("dump_id1", dump_id[1], e.id);
            chk("dump_score0", dump_score[0], e.s0);
            chk("dump_score1", dump_score[1], e.s1);
            chk("dump_last0", dump_last[0], e.last);
            chk("dump_last1", dump_last[1], e.last);
            if (e.c != 0) chk("dump_cycle", cyc, e.c);
          end
        end else begin
          stalled = 1;
          sid = dump_id[0]; ss0 = dump_score[0]; ss1 = dump_score[1]; sl = dump_last[0];
        end
      end else if (stalled) begin
        chk("dump_valid_dropped", 0, 1);
        stalled = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bd_data[0] = '0; bd_data[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    #2 rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) backdoor(3'(i), 16'(i * 3), 16'(i * 3));
    do_dump(0);

    backdoor(3'd2, 16'd0, 16'd0);
    backdoor(3'd5, 16'd0, 16'd0);
    backdoor(3'd1, 16'd0, 16'd0);
    do_update(3'd2, 16'd50, 1, 0);
    do_update(3'd5, 16'd50, 1, 0);
    do_update(3'd1, 16'd60, 1, 0);

    backdoor(3'd7, 16'd10, 16'd10);
    do_update(3'd7, 16'd5, 1, 0);
    backdoor(3'd3, 16'hFFF0, 16'hFFF0);
    do_update(3'd3, 16'h0020, 1, 0);
    backdoor(3'd4, 16'd40, 16'd40);
    do_update(3'd4, 16'd25, 1, 0);

    do_update(3'd5, 16'd7, 20, 0);
    repeat (10) begin @(posedge clk); #1; end
    chk("pending_after_hold", wr_q.size(), 0);
    do_update(3'd6, 16'd11, 1, 1);
    repeat (10) begin @(posedge clk); #1; end
    chk("pending_after_toggle", wr_q.size(), 0);

    for (int i = 0; i < 24; i++) begin
      logic [15:0] sc;
      sc = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hF000, 16'hFFFF))
                                       : 16'($urandom_range(0, 300));
      do_update(3'($urandom_range(0, 7)), sc, 1, 0);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    do_dump(1);

    // Reset while an update waits on RAM data: the write must never happen
    wait_idle();
    game_state = 2'b01; userid = 3'd6; score_data = 16'd9;
    @(posedge clk); #1;
    game_state = 2'b00;
    @(posedge clk); #1;
    #1 rst = 1'b0;
    #1 check_reset_outputs("rst_uwait");
    release_reset();
    repeat (8) begin @(posedge clk); #1; end
    do_update(3'd6, 16'd9, 1, 0);

    // Reset while a dump entry is stalled on the consumer
    wait_idle();
    ready_mode = 0;
    game_state = 2'b10;
    @(posedge clk); #1;
    game_state = 2'b00;
    n = 0;
    while (!dump_valid[0] && n < 20) begin @(posedge clk); #1; n++; end
    chk("dump_valid_seen", dump_valid[0], 1);
    #1 rst = 1'b0;
    #1 check_reset_outputs("rst_dout");
    release_reset();
    repeat (4) begin @(posedge clk); #1; end
    do_update(3'd0, 16'd123, 1, 0);
    do_dump(0);

    repeat (5) begin @(posedge clk); #1; end
    chk("final_write_queue", wr_q.size(), 0);
    chk("final_dump_queue", dp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
